// File: rtl/serial_bit_feeder_if.sv
// -----------------------------------------------------------------------------
// serial_bit_feeder_if
// Parallel-word input handshake of the serial bit feeder.
//   din        : parallel word offered by the producer
//   din_valid  : producer offers din this cycle
//   din_ready  : feeder FIFO can take a word; a push happens on a rising edge
//                where din_valid && din_ready
// Modports: master = word producer, slave = serial_bit_feeder.
// -----------------------------------------------------------------------------
interface serial_bit_feeder_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;

    modport master (
        output din,
        output din_valid,
        input  din_ready
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready
    );
endinterface

// File: rtl/serial_bit_feeder.sv
// -----------------------------------------------------------------------------
// serial_bit_feeder
// Buffers parallel words in a small FIFO and shifts them out one bit per clock
// as the x stream of the serial sequence detector. Words leave back-to-back
// with no idle gaps; x_valid marks real data bits.
//
// Ports:
//   i_clk         : system clock, rising edge
//   i_rst         : asynchronous reset, active-high
//   s_in          : word handshake (din / din_valid / din_ready), slave side
//   i_msb_first   : bit order, sampled when a word is popped into the shifter
//   o_x           : registered serial bit
//   o_x_valid     : o_x carries a data bit
//   o_word_done   : high while o_x presents the last bit of a word
//   o_busy        : shifter active or FIFO non-empty
//   o_fifo_count  : occupied FIFO entries
//
// Optional feature macro: SERIAL_FEEDER_PRBS_FILL_EN
//   When defined, x carries PRBS7 fill bits (x_valid low) while idle with an
//   empty FIFO instead of IDLE_BIT.
// -----------------------------------------------------------------------------
module serial_bit_feeder #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 4,
    parameter logic        IDLE_BIT = 1'b0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    serial_bit_feeder_if.slave       s_in,
    input  logic                     i_msb_first,
    output logic                     o_x,
    output logic                     o_x_valid,
    output logic                     o_word_done,
    output logic                     o_busy,
    output logic [$clog2(DEPTH):0]   o_fifo_count
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CW   = $clog2(WIDTH);
    localparam int unsigned CNTW = AW + 1;
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

    state_t            r_state, w_state_nx;
    logic [WIDTH-1:0]  r_sr, w_sr_nx;        // bits still to be shifted out
    logic [CW-1:0]     r_cnt, w_cnt_nx;      // bits remaining after the one on x
    logic              r_msb, w_msb_nx;      // order latched at pop
    logic              r_x, w_x_nx;
    logic              r_x_valid, w_x_valid_nx;
    logic              r_word_done, w_word_done_nx;
    logic              r_busy, w_busy_nx;
    logic [CNTW-1:0]   r_count, w_count_nx;
    logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [WIDTH-1:0]  w_head;
    logic              w_push, w_pop, w_last;
`ifdef SERIAL_FEEDER_PRBS_FILL_EN
    logic [6:0]        r_lfsr, w_lfsr_nx;
`endif

    // Ready is forced low while reset is held so nothing is pushed during reset.
    assign s_in.din_ready = ~i_rst & (r_count != FULL_CNT);

    assign w_push = s_in.din_valid & s_in.din_ready;
    assign w_last = (r_state == ST_SHIFT) && (r_cnt == '0);
    // Pop when idle, or on the last bit so the next word follows without a gap.
    assign w_pop  = (r_count != '0) && ((r_state == ST_IDLE) || w_last);
    assign w_head = r_mem[r_rd_ptr];

    // Next-state, shifter and output decode.
    always_comb begin
        w_state_nx   = r_state;
        w_sr_nx      = r_sr;
        w_cnt_nx     = r_cnt;
        w_msb_nx     = r_msb;
        w_x_nx       = r_x;
        w_x_valid_nx = r_x_valid;
`ifdef SERIAL_FEEDER_PRBS_FILL_EN
        w_lfsr_nx    = r_lfsr;
`endif
        if (w_pop) begin
            w_state_nx   = ST_SHIFT;
            w_msb_nx     = i_msb_first;
            w_cnt_nx     = CNT_LAST;
            w_x_valid_nx = 1'b1;
            if (i_msb_first) begin
                w_x_nx  = w_head[WIDTH-1];
                w_sr_nx = w_head << 1'b1;
            end else begin
                w_x_nx  = w_head[0];
                w_sr_nx = w_head >> 1'b1;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_x_valid_nx = 1'b0;
`ifdef SERIAL_FEEDER_PRBS_FILL_EN
                    w_x_nx    = r_lfsr[6];
                    w_lfsr_nx = {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
`else
                    w_x_nx    = IDLE_BIT;
`endif
                end
                ST_SHIFT: begin
                    if (r_cnt != '0) begin
                        w_cnt_nx = r_cnt - CNT_ONE;
                        if (r_msb) begin
                            w_x_nx  = r_sr[WIDTH-1];
                            w_sr_nx = r_sr << 1'b1;
                        end else begin
                            w_x_nx  = r_sr[0];
                            w_sr_nx = r_sr >> 1'b1;
                        end
                    end else begin
                        w_state_nx   = ST_IDLE;
                        w_x_nx       = IDLE_BIT;
                        w_x_valid_nx = 1'b0;
                    end
                end
                default: begin
                    w_state_nx   = ST_IDLE;
                    w_x_nx       = IDLE_BIT;
                    w_x_valid_nx = 1'b0;
                end
            endcase
        end

        case ({w_push, w_pop})
            2'b10:   w_count_nx = r_count + CNTW'(1);
            2'b01:   w_count_nx = r_count - CNTW'(1);
            default: w_count_nx = r_count;
        endcase

        w_word_done_nx = w_x_valid_nx && (w_cnt_nx == '0);
        w_busy_nx      = (w_state_nx == ST_SHIFT) || (w_count_nx != '0);
    end

    // State, shifter, FIFO pointers and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_sr        <= '0;
            r_cnt       <= '0;
            r_msb       <= 1'b0;
            r_x         <= IDLE_BIT;
            r_x_valid   <= 1'b0;
            r_word_done <= 1'b0;
            r_busy      <= 1'b0;
            r_count     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_sr        <= w_sr_nx;
            r_cnt       <= w_cnt_nx;
            r_msb       <= w_msb_nx;
            r_x         <= w_x_nx;
            r_x_valid   <= w_x_valid_nx;
            r_word_done <= w_word_done_nx;
            r_busy      <= w_busy_nx;
            r_count     <= w_count_nx;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
        end
    end

    // FIFO storage; contents are don't-care while empty so no reset is needed.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_in.din;
        end
    end

`ifdef SERIAL_FEEDER_PRBS_FILL_EN
    // PRBS7 fill generator; only advances while idle with nothing to pop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lfsr <= 7'h01;
        end else begin
            r_lfsr <= w_lfsr_nx;
        end
    end
`endif

    assign o_x          = r_x;
    assign o_x_valid    = r_x_valid;
    assign o_word_done  = r_word_done;
    assign o_busy       = r_busy;
    assign o_fifo_count = r_count;
endmodule

// File: tb/tb_serial_bit_feeder.sv
// -----------------------------------------------------------------------------
// tb_serial_bit_feeder
// Directed bench for serial_bit_feeder (WIDTH=8, DEPTH=4, IDLE_BIT=0).
// Expected bit sequences are written out by hand from the input words.
// -----------------------------------------------------------------------------
module tb_serial_bit_feeder;
    logic       clk;
    logic       rst;
    logic       msb_first;
    logic       x, x_valid, word_done, busy;
    logic [2:0] fifo_count;
    int         n_cmp;
    int         n_mis;

    serial_bit_feeder_if #(.WIDTH(8)) bus ();

    serial_bit_feeder #(.WIDTH(8), .DEPTH(4), .IDLE_BIT(1'b0)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .s_in         (bus),
        .i_msb_first  (msb_first),
        .o_x          (x),
        .o_x_valid    (x_valid),
        .o_word_done  (word_done),
        .o_busy       (busy),
        .o_fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one word into an idle, empty feeder and check its 8 output bits.
    // expseq holds the expected x sequence, first bit in expseq[7].
    task automatic send_word(input logic [7:0] w, input logic msb, input logic [7:0] expseq,
                             input logic flip_order);
        bus.din       = w;
        bus.din_valid = 1'b1;
        msb_first     = msb;
        tick();
        bus.din_valid = 1'b0;
        check("push_count", 32'(fifo_count), 32'd1);
        check("push_xvalid", 32'(x_valid), 32'd0);
        check("push_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (flip_order && i == 0) msb_first = ~msb;
            check($sformatf("bit%0d_x", i), 32'(x), 32'(expseq[7-i]));
            check($sformatf("bit%0d_xvalid", i), 32'(x_valid), 32'd1);
            check($sformatf("bit%0d_done", i), 32'(word_done), (i == 7) ? 32'd1 : 32'd0);
        end
        tick();
        check("after_xvalid", 32'(x_valid), 32'd0);
        check("after_done", 32'(word_done), 32'd0);
        check("after_busy", 32'(busy), 32'd0);
`ifndef SERIAL_FEEDER_PRBS_FILL_EN
        check("after_idle_x", 32'(x), 32'd0);
`endif
    endtask

    logic [7:0]  words [6];
    int          cnt_tab [11];
    int          rdy_tab [11];
    logic [47:0] stream;
    int          idx;
    logic        rdy;
    logic        exp_xv;
    logic        exp_wd;
`ifdef SERIAL_FEEDER_PRBS_FILL_EN
    logic [6:0]  model;
    logic        exp_bit;
`endif

    initial begin
        n_cmp = 0;
        n_mis = 0;
        rst           = 1'b1;
        bus.din       = 8'h00;
        bus.din_valid = 1'b0;
        msb_first     = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_x", 32'(x), 32'd0);
        check("rst_xvalid", 32'(x_valid), 32'd0);
        check("rst_done", 32'(word_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ready", 32'(bus.din_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("rel_ready", 32'(bus.din_ready), 32'd1);

`ifdef SERIAL_FEEDER_PRBS_FILL_EN
        // PRBS7 fill while idle, reference from seed 7'h01
        model = 7'h01;
        for (int i = 0; i < 20; i++) begin
            tick();
            exp_bit = model[6];
            model   = {model[5:0], model[6] ^ model[5]};
            check($sformatf("prbs%0d_x", i), 32'(x), 32'(exp_bit));
            check($sformatf("prbs%0d_xvalid", i), 32'(x_valid), 32'd0);
        end
        send_word(8'h81, 1'b1, 8'b1000_0001, 1'b0);
`endif

        // 8'hB4 MSB first: 1,0,1,1,0,1,0,0
        send_word(8'hB4, 1'b1, 8'b1011_0100, 1'b0);
        // 8'hB4 LSB first: 0,0,1,0,1,1,0,1 ; order flipped mid-word has no effect
        send_word(8'hB4, 1'b0, 8'b0010_1101, 1'b1);

        // Back-to-back words with the FIFO filling up and a push held while full
        words[0] = 8'hFF; words[1] = 8'h00; words[2] = 8'hA5;
        words[3] = 8'h3C; words[4] = 8'hC3; words[5] = 8'h5A;
        cnt_tab = '{1, 1, 2, 3, 4, 4, 4, 4, 4, 3, 4};
        rdy_tab = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0};
        stream  = 48'hFF00_A53C_C35A;
        msb_first = 1'b1;
        idx = 0;
        for (int c = 1; c <= 50; c++) begin
            bus.din       = (idx < 6) ? words[idx] : 8'h00;
            bus.din_valid = (idx < 6);
            rdy           = bus.din_ready;
            tick();
            if (bus.din_valid && rdy) idx++;
            exp_xv = (c >= 2) && (c <= 49);
            exp_wd = (c >= 9) && (c <= 49) && (((c - 9) % 8) == 0);
            check($sformatf("b2b%0d_xvalid", c), 32'(x_valid), 32'(exp_xv));
            check($sformatf("b2b%0d_done", c), 32'(word_done), 32'(exp_wd));
            if (exp_xv) check($sformatf("b2b%0d_x", c), 32'(x), 32'(stream[47-(c-2)]));
            if (c <= 11) begin
                check($sformatf("b2b%0d_count", c), 32'(fifo_count), 32'(cnt_tab[c-1]));
                check($sformatf("b2b%0d_ready", c), 32'(bus.din_ready), 32'(rdy_tab[c-1]));
            end
            if (c == 49) check("b2b_last_count", 32'(fifo_count), 32'd0);
            if (c == 50) check("b2b_end_busy", 32'(busy), 32'd0);
        end
        bus.din_valid = 1'b0;

        // Reset 3 bits into a word, then a fresh word
        bus.din       = 8'hAA;
        bus.din_valid = 1'b1;
        msb_first     = 1'b1;
        tick();
        bus.din_valid = 1'b0;
        tick();
        tick();
        tick();
        check("mid_xvalid", 32'(x_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_x", 32'(x), 32'd0);
        check("mid_rst_xvalid", 32'(x_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_ready", 32'(bus.din_ready), 32'd0);
        tick();
        check("mid_rst_hold_ready", 32'(bus.din_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("mid_rel_ready", 32'(bus.din_ready), 32'd1);
        @(posedge clk);
        #1;
        check("mid_idle_xvalid", 32'(x_valid), 32'd0);
        check("mid_idle_busy", 32'(busy), 32'd0);
        // 8'h0F MSB first: 0,0,0,0,1,1,1,1
        send_word(8'h0F, 1'b1, 8'b0000_1111, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
